seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, handshaked successor to the combinational datapath ALU. Executes the 16 single-cycle function codes plus iterative unsigned multiply, divide and remainder. Uses a one-entry valid/ready request/response protocol so a control FSM can stall on it. Sits between the register-file read stage and writeback in the multicycle CPU.

Parameters:
DATA_WIDTH, 16, operand/result width (>=4)
OP_WIDTH, 5, function code width (fixed 5; codes 0-18 defined)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  block can accept request
A  input  DATA_WIDTH  operand A
B  input  DATA_WIDTH  operand B
FuncCode  input  OP_WIDTH  operation select
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
C  output  DATA_WIDTH  result
OverflowFlag  output  1  signed ADD/SUB/TCP overflow, or MUL high-half nonzero
DivZeroFlag  output  1  DIVU/REMU with B==0

Behaviour:
- Reset (async, active-high): state IDLE; in_ready=1; out_valid=0; C=0; OverflowFlag=0; DivZeroFlag=0; iteration counter=0. A reset asserted mid-operation aborts the operation with no result.
- Request accepted when in_valid && in_ready. A, B and FuncCode are latched at acceptance; later input changes have no effect.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: iterative op in progress; in_ready=0.
  - DONE: out_valid=1; in_ready=0.
- FSM transitions:
  - IDLE->DONE on accepting a code 0-15 or an undefined code.
  - IDLE->BUSY on accepting code 16-18.
  - BUSY->DONE after exactly DATA_WIDTH iteration cycles.
  - DONE->IDLE when out_ready=1.
- Single-cycle codes, result 1 cycle after accept:
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 ID A
  - 3 NOT ~A
  - 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR
  - 10 LLS A<<1
  - 11 LRS A>>1 logical
  - 12 ALS A<<1
  - 13 ARS A>>>1 sign-filling
  - 14 TCP ~A+1
  - 15 ZERO 0
- Iterative codes, result DATA_WIDTH+1 cycles after accept:
  - 16 MULU: shift-add; C = low DATA_WIDTH bits of the 2*DATA_WIDTH product; OverflowFlag=1 iff high half nonzero.
  - 17 DIVU: restoring division; C = quotient.
  - 18 REMU: C = remainder.
- Divide by zero: B==0 with DIVU gives C=all ones; with REMU gives C=A. Both set DivZeroFlag=1 and take the full DATA_WIDTH+1 latency.
- Codes 19-31: C=0, both flags 0, single-cycle.
- OverflowFlag:
  - ADD: operands same sign, result sign differs.
  - SUB: operand signs differ, result sign differs from A.
  - TCP: A == most-negative value.
  - All other ops: 0.
- DivZeroFlag is 0 for every op except DIVU/REMU with B==0.
- C and the flags are registered. They are held stable while out_valid=1 and out_ready=0, and keep their last value after the handshake completes.
- A new request cannot be accepted in the same cycle the result is consumed. Back-to-back single-cycle throughput is one result per 2 cycles.
- Arithmetic wraps modulo 2^DATA_WIDTH. Shifts by exactly 1.

Optional Feature:
Macro SEQ_ALU_STATUS_FLAGS_EN.
- Defined: adds outputs ZeroFlag (1 bit, C==0) and NegFlag (1 bit, C[DATA_WIDTH-1]).
  - Both registered with C and reset to 0.
  - Valid under the same rules as OverflowFlag.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset mid-MULU (A=16'h00FF, B=16'h0101, reset on cycle 5) -> out_valid=0, in_ready=1, C=0 immediately. The next request is serviced normally.
2. ADD A=16'h7FFF, B=16'h0001, out_ready=1 -> out_valid one cycle after accept, C=16'h8000, OverflowFlag=1. Then ARS A=16'h8002 -> C=16'hC001, OverflowFlag=0.
3. MULU A=16'h0100, B=16'h0100 -> out_valid exactly 17 cycles after accept, C=16'h0000, OverflowFlag=1. MULU A=16'h00FF, B=16'h0003 -> C=16'h02FD, OverflowFlag=0.
4. DIVU A=16'd1000, B=16'd7 -> C=16'd142. REMU same operands -> C=16'd6. DIVU with B=0 -> C=16'hFFFF, DivZeroFlag=1. REMU A=16'h1234, B=0 -> C=16'h1234, DivZeroFlag=1.
5. Backpressure: SUB A=16'h8000, B=16'h0001, out_ready held 0 for 10 cycles while A/B/in_valid toggle -> C=16'h7FFF, OverflowFlag=1 held stable, in_ready=0 throughout. After out_ready=1, in_ready returns the next cycle.
6. DATA_WIDTH=8 instance: TCP A=8'h80 -> C=8'h80, OverflowFlag=1. Code 20 -> C=0. MULU 8'h10*8'h10 -> latency 9, C=8'h00, OverflowFlag=1.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: 16 single-cycle codes plus iterative MULU/DIVU/REMU.
// Optional ZeroFlag/NegFlag outputs are enabled with `define SEQ_ALU_STATUS_FLAGS_EN.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// BUSY  | iterative multiply/divide in progress
// DONE  | result held on C/flags (out_valid=1) until out_ready
module seq_alu #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [OP_WIDTH-1:0]   FuncCode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] C,
    output logic                  OverflowFlag,
`ifdef SEQ_ALU_STATUS_FLAGS_EN
    output logic                  DivZeroFlag,
    output logic                  ZeroFlag,
    output logic                  NegFlag
`else
    output logic                  DivZeroFlag
`endif
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_ID   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_NOT  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_NAND = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_XNOR = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_LLS  = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_LRS  = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_ALS  = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_ARS  = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_TCP  = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_ZERO = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_MULU = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_DIVU = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] OP_REMU = OP_WIDTH'(18);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]          state;
    logic [OP_WIDTH-1:0] opReg;
    logic [W-1:0]        aReg;
    logic [W-1:0]        bReg;
    logic [W-1:0]        accHi;
    logic [W-1:0]        accLo;
    logic [CNT_W-1:0]    iterCnt;

    logic [W-1:0] sC;
    logic         sOv;
    logic         isIter;

    logic [W:0]   mulSum;
    logic [W-1:0] mulHiN;
    logic [W-1:0] mulLoN;
    logic [W:0]   divShift;
    logic [W:0]   divDiff;
    logic         divOk;
    logic [W-1:0] divRemN;
    logic [W-1:0] divQuoN;
    logic [W-1:0] stepHi;
    logic [W-1:0] stepLo;
    logic         bZero;

    logic [W-1:0] iterC;
    logic         iterOv;
    logic         iterDz;
    logic [W-1:0] resC;
    logic         resOv;
    logic         resDz;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign isIter = (FuncCode == OP_MULU) || (FuncCode == OP_DIVU) || (FuncCode == OP_REMU);

    always_comb begin
        sC  = '0;
        sOv = 1'b0;
        case (FuncCode)
            OP_ADD: begin
                sC  = A + B;
                sOv = (A[W-1] == B[W-1]) && (sC[W-1] != A[W-1]);
            end
            OP_SUB: begin
                sC  = A - B;
                sOv = (A[W-1] != B[W-1]) && (sC[W-1] != A[W-1]);
            end
            OP_ID:   sC = A;
            OP_NOT:  sC = ~A;
            OP_AND:  sC = A & B;
            OP_OR:   sC = A | B;
            OP_NAND: sC = ~(A & B);
            OP_NOR:  sC = ~(A | B);
            OP_XOR:  sC = A ^ B;
            OP_XNOR: sC = ~(A ^ B);
            OP_LLS:  sC = {A[W-2:0], 1'b0};
            OP_LRS:  sC = {1'b0, A[W-1:1]};
            OP_ALS:  sC = {A[W-2:0], 1'b0};
            OP_ARS:  sC = {A[W-1], A[W-1:1]};
            OP_TCP: begin
                sC  = ~A + 1'b1;
                sOv = (A == MOST_NEG);
            end
            OP_ZERO: sC = '0;
            default: sC = '0;
        endcase
    end

    // Shift-add multiply: accHi is the running partial product, accLo the multiplier
    // being shifted out LSB-first while product bits shift in from the top.
    assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, bReg} : {(W+1){1'b0}});
    assign mulHiN = mulSum[W:1];
    assign mulLoN = {mulSum[0], accLo[W-1:1]};

    // Restoring divide: accHi is the partial remainder, accLo the dividend/quotient.
    assign divShift = {accHi, accLo[W-1]};
    assign divDiff  = divShift - {1'b0, bReg};
    assign divOk    = ~divDiff[W];
    assign divRemN  = divOk ? divDiff[W-1:0] : divShift[W-1:0];
    assign divQuoN  = {accLo[W-2:0], divOk};

    assign stepHi = (opReg == OP_MULU) ? mulHiN : divRemN;
    assign stepLo = (opReg == OP_MULU) ? mulLoN : divQuoN;
    assign bZero  = (bReg == '0);

    always_comb begin
        iterC  = mulLoN;
        iterOv = 1'b0;
        iterDz = 1'b0;
        case (opReg)
            OP_MULU: begin
                iterC  = mulLoN;
                iterOv = |mulHiN;
            end
            OP_DIVU: begin
                iterC  = bZero ? {W{1'b1}} : divQuoN;
                iterDz = bZero;
            end
            OP_REMU: begin
                iterC  = bZero ? aReg : divRemN;
                iterDz = bZero;
            end
            default: iterC = mulLoN;
        endcase
    end

    always_comb begin
        resC  = sC;
        resOv = sOv;
        resDz = 1'b0;
        if (state == BUSY) begin
            resC  = iterC;
            resOv = iterOv;
            resDz = iterDz;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            opReg        <= '0;
            aReg         <= '0;
            bReg         <= '0;
            accHi        <= '0;
            accLo        <= '0;
            iterCnt      <= '0;
            C            <= '0;
            OverflowFlag <= 1'b0;
            DivZeroFlag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opReg <= FuncCode;
                        aReg  <= A;
                        bReg  <= B;
                        if (isIter) begin
                            state   <= BUSY;
                            iterCnt <= CNT_W'(DATA_WIDTH);
                            accHi   <= '0;
                            accLo   <= A;
                        end else begin
                            state        <= DONE;
                            C            <= resC;
                            OverflowFlag <= resOv;
                            DivZeroFlag  <= resDz;
                        end
                    end
                end
                BUSY: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    if (iterCnt == CNT_W'(1)) begin
                        iterCnt      <= '0;
                        state        <= DONE;
                        C            <= resC;
                        OverflowFlag <= resOv;
                        DivZeroFlag  <= resDz;
                    end else begin
                        iterCnt <= iterCnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_ALU_STATUS_FLAGS_EN
    // Status flags track C exactly, so they load on the same conditions.
    logic resLoad;
    assign resLoad = ((state == IDLE) && in_valid && !isIter) ||
                     ((state == BUSY) && (iterCnt == CNT_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ZeroFlag <= 1'b0;
            NegFlag  <= 1'b0;
        end else if (resLoad) begin
            ZeroFlag <= (resC == '0);
            NegFlag  <= resC[W-1];
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus random ops on 16- and 8-bit
// instances, checked against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] aBus, bBus;
    logic [4:0]  fc;
    logic        iv16, iv8, or16, or8;
    logic        ir16, ir8, vld16, vld8;
    logic [15:0] c16;
    logic [7:0]  c8;
    logic        ovf16, ovf8, dz16, dz8;
`ifdef SEQ_ALU_STATUS_FLAGS_EN
    logic        zf16, nf16, zf8, nf8;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.DATA_WIDTH(16), .OP_WIDTH(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .A(aBus), .B(bBus), .FuncCode(fc), .out_valid(vld16), .out_ready(or16),
        .C(c16), .OverflowFlag(ovf16),
`ifdef SEQ_ALU_STATUS_FLAGS_EN
        .DivZeroFlag(dz16), .ZeroFlag(zf16), .NegFlag(nf16)
`else
        .DivZeroFlag(dz16)
`endif
    );

    seq_alu #(.DATA_WIDTH(8), .OP_WIDTH(5)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .A(aBus[7:0]), .B(bBus[7:0]), .FuncCode(fc), .out_valid(vld8), .out_ready(or8),
        .C(c8), .OverflowFlag(ovf8),
`ifdef SEQ_ALU_STATUS_FLAGS_EN
        .DivZeroFlag(dz8), .ZeroFlag(zf8), .NegFlag(nf8)
`else
        .DivZeroFlag(dz8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cOf(input int w);
        return (w == 16) ? {48'd0, c16} : {56'd0, c8};
    endfunction
    function automatic logic rdyOf(input int w);
        return (w == 16) ? ir16 : ir8;
    endfunction
    function automatic logic vldOf(input int w);
        return (w == 16) ? vld16 : vld8;
    endfunction
    function automatic logic ovOf(input int w);
        return (w == 16) ? ovf16 : ovf8;
    endfunction
    function automatic logic dzOf(input int w);
        return (w == 16) ? dz16 : dz8;
    endfunction

    task automatic setIv(input int w, input logic v);
        if (w == 16) iv16 = v;
        else         iv8  = v;
    endtask

    // Reference: operands as unsigned integers, signed views for overflow, plain arithmetic.
    function automatic void refModel(input int w, input int op, input longint a, input longint b,
                                     output longint c, output bit ov, output bit dz);
        longint m, half, sa, sb, r, p;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - (m + 1) : a;
        sb   = (b >= half) ? b - (m + 1) : b;
        ov   = 1'b0;
        dz   = 1'b0;
        c    = 0;
        case (op)
            0:  begin c = (a + b) & m; r = sa + sb; ov = (r >= half) || (r < -half); end
            1:  begin c = (a - b) & m; r = sa - sb; ov = (r >= half) || (r < -half); end
            2:  c = a;
            3:  c = ~a & m;
            4:  c = a & b;
            5:  c = a | b;
            6:  c = ~(a & b) & m;
            7:  c = ~(a | b) & m;
            8:  c = a ^ b;
            9:  c = ~(a ^ b) & m;
            10, 12: c = (a * 2) & m;
            11: c = a / 2;
            13: c = (sa >>> 1) & m;
            14: begin c = (-a) & m; ov = (-sa) >= half; end
            15: c = 0;
            16: begin p = a * b; c = p & m; ov = (p >> w) != 0; end
            17: begin dz = (b == 0); c = (b == 0) ? m : a / b; end
            18: begin dz = (b == 0); c = (b == 0) ? a : a % b; end
            default: c = 0;
        endcase
    endfunction

    // One request with out_ready held high: checks latency, result, flags, and return to idle.
    task automatic xact(input int w, input int op, input logic [15:0] a, input logic [15:0] b,
                        output logic [63:0] cObs, output logic ovObs);
        longint m, expC;
        bit expOv, expDz;
        int lat, expLat;
        string t;
        m = (longint'(1) << w) - 1;
        t = $sformatf("w%0d op%0d a=%0h b=%0h", w, op, a, b);
        @(negedge clk);
        aBus = a; bBus = b; fc = op[4:0]; setIv(w, 1'b1);
        check({t, " in_ready_before"}, 64'(rdyOf(w)), 64'd1);
        @(posedge clk); #1;
        setIv(w, 1'b0);
        lat = 1;
        while (vldOf(w) !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        refModel(w, op, longint'(a) & m, longint'(b) & m, expC, expOv, expDz);
        expLat = (op >= 16 && op <= 18) ? w + 1 : 1;
        check({t, " latency"}, 64'(lat), 64'(expLat));
        check({t, " C"}, cOf(w), 64'(expC));
        check({t, " OverflowFlag"}, 64'(ovOf(w)), 64'(expOv));
        check({t, " DivZeroFlag"}, 64'(dzOf(w)), 64'(expDz));
`ifdef SEQ_ALU_STATUS_FLAGS_EN
        check({t, " ZeroFlag"}, 64'((w == 16) ? zf16 : zf8), 64'(expC == 0));
        check({t, " NegFlag"}, 64'((w == 16) ? nf16 : nf8), 64'((expC >> (w - 1)) & 1));
`endif
        cObs  = cOf(w);
        ovObs = ovOf(w);
        @(posedge clk); #1;
        check({t, " in_ready_after"}, 64'(rdyOf(w)), 64'd1);
        check({t, " out_valid_after"}, 64'(vldOf(w)), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] cr;
        logic        ovr;
        logic [15:0] ra, rb;
        int          rop;

        reset = 1'b1; iv16 = 1'b0; iv8 = 1'b0; or16 = 1'b1; or8 = 1'b1;
        aBus = '0; bBus = '0; fc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(vld16), 64'd0);
        check("reset in_ready", 64'(ir16), 64'd1);
        check("reset C", 64'(c16), 64'd0);
        check("reset OverflowFlag", 64'(ovf16), 64'd0);
        check("reset DivZeroFlag", 64'(dz16), 64'd0);
        @(negedge clk); reset = 1'b0;

        // ADD overflow, then arithmetic shift right
        xact(16, 0, 16'h7FFF, 16'h0001, cr, ovr);
        check("add C const", cr, 64'h8000);
        check("add ovf const", 64'(ovr), 64'd1);
        xact(16, 13, 16'h8002, 16'h0000, cr, ovr);
        check("ars C const", cr, 64'hC001);

        // Reset mid-MULU aborts; C nonzero beforehand so its clearing is visible
        @(negedge clk);
        aBus = 16'h00FF; bBus = 16'h0101; fc = 5'd16; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (4) @(posedge clk);
        #1; reset = 1'b1; #1;
        check("midreset out_valid", 64'(vld16), 64'd0);
        check("midreset in_ready", 64'(ir16), 64'd1);
        check("midreset C", 64'(c16), 64'd0);
        @(negedge clk); reset = 1'b0;
        xact(16, 16, 16'h00FF, 16'h0101, cr, ovr);

        // Multiply
        xact(16, 16, 16'h0100, 16'h0100, cr, ovr);
        check("mulu ovf const", 64'(ovr), 64'd1);
        xact(16, 16, 16'h00FF, 16'h0003, cr, ovr);
        check("mulu C const", cr, 64'h02FD);

        // Divide / remainder including divide-by-zero
        xact(16, 17, 16'd1000, 16'd7, cr, ovr);
        check("divu C const", cr, 64'd142);
        xact(16, 18, 16'd1000, 16'd7, cr, ovr);
        check("remu C const", cr, 64'd6);
        xact(16, 17, 16'h5555, 16'h0000, cr, ovr);
        xact(16, 18, 16'h1234, 16'h0000, cr, ovr);
        check("remu0 C const", cr, 64'h1234);

        // Backpressure: result held while inputs churn
        @(negedge clk);
        or16 = 1'b0; aBus = 16'h8000; bBus = 16'h0001; fc = 5'd1; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            aBus = 16'($urandom); bBus = 16'($urandom); fc = 5'($urandom); iv16 = i[0];
            @(posedge clk); #1;
            check($sformatf("bp%0d C", i), 64'(c16), 64'h7FFF);
            check($sformatf("bp%0d ovf", i), 64'(ovf16), 64'd1);
            check($sformatf("bp%0d in_ready", i), 64'(ir16), 64'd0);
            check($sformatf("bp%0d out_valid", i), 64'(vld16), 64'd1);
        end
        @(negedge clk); iv16 = 1'b0; or16 = 1'b1;
        @(posedge clk); #1;
        check("bp release in_ready", 64'(ir16), 64'd1);
        check("bp release C kept", 64'(c16), 64'h7FFF);

        // 8-bit instance
        xact(8, 14, 16'h0080, 16'h0000, cr, ovr);
        check("w8 tcp C const", cr, 64'h80);
        check("w8 tcp ovf const", 64'(ovr), 64'd1);
        xact(8, 20, 16'h00AB, 16'h00CD, cr, ovr);
        check("w8 code20 C const", cr, 64'h0);
        xact(8, 16, 16'h0010, 16'h0010, cr, ovr);
        check("w8 mulu ovf const", 64'(ovr), 64'd1);

        // Every code once on each width, then random traffic
        for (int op = 0; op < 32; op++) begin
            xact(16, op, 16'hA5C3, 16'h0F1E, cr, ovr);
            xact(8, op, 16'h00C3, 16'h001E, cr, ovr);
        end
        for (int i = 0; i < 60; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 18)) : int'($urandom_range(0, 31));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            xact((i % 3 == 0) ? 8 : 16, rop, ra, rb, cr, ovr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
